// File: rtl/pc_sequencer_irq.sv
// Program counter sequencer for the single-cycle MIPS core.
// Selects the next fetch address (sequential, branch, jump, jr, or one of the
// reset/interrupt/exception vectors), tracks kernel mode as pc[31], latches
// timer interrupts and supplies the $k0 return address when a vector is taken.
module pc_sequencer_irq #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic        exc_undef,
  input  logic        irq_in,
  output logic [31:0] pc,
  output logic        kernel,
  output logic        flush,
  output logic        k0_we,
  output logic [31:0] k0_wdata,
  output logic        irq_pending
);

  localparam logic [1:0] SrcSeq    = 2'd0;
  localparam logic [1:0] SrcBranch = 2'd1;
  localparam logic [1:0] SrcJump   = 2'd2;
  localparam logic [1:0] SrcJr     = 2'd3;

  logic [31:0] pc_q, pc_d;
  logic        irq_pending_q, irq_pending_d;
  logic        irq_in_q, irq_in_d;

  logic [31:0] pc_plus4;
  logic [31:0] jr_eff;
  logic        irq_rise;
  logic        take_exc;
  logic        take_irq;

  // Vector-take decisions and the values handed to the register file.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    irq_rise = irq_in & ~irq_in_q;
    take_exc = exc_undef & ~stall;
    // Exceptions outrank interrupts; kernel mode masks interrupts.
    take_irq = irq_pending_q & ~pc_q[31] & ~stall & ~exc_undef;
    // A faulting instruction is skipped, a preempted one is re-executed.
    k0_wdata = take_exc ? pc_plus4 : pc_q;
    flush    = ~reset & (take_exc | take_irq);
    k0_we    = ~reset & (take_exc | take_irq);
    // User code may not jump into kernel space through jr.
    jr_eff   = {jr_target[31] & pc_q[31], jr_target[30:2], 2'b00};
  end

  // Next-state selection: reset, then vectors, then stall, then pc_src.
  always_comb begin
    pc_d          = pc_q;
    irq_in_d      = irq_in;
    // Set on rise wins over clear on take.
    irq_pending_d = irq_rise ? 1'b1 : (take_irq ? 1'b0 : irq_pending_q);
    if (reset) begin
      pc_d          = RESET_VEC;
      irq_pending_d = 1'b0;
      irq_in_d      = 1'b0;
    end else if (take_exc) begin
      pc_d = EXC_VEC;
    end else if (take_irq) begin
      pc_d = IRQ_VEC;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      unique case (pc_src)
        SrcSeq:    pc_d = pc_plus4;
        SrcBranch: pc_d = {branch_target[31:2], 2'b00};
        SrcJump:   pc_d = {pc_q[31:28], jump_index, 2'b00};
        SrcJr:     pc_d = jr_eff;
        default:   pc_d = pc_plus4;
      endcase
    end
  end

  // State registers with synchronous active-high reset folded into *_d.
  always_ff @(posedge clk) begin
    pc_q          <= pc_d;
    irq_pending_q <= irq_pending_d;
    irq_in_q      <= irq_in_d;
  end

  // Outputs derived directly from state.
  always_comb begin
    pc          = pc_q;
    kernel      = pc_q[31];
    irq_pending = irq_pending_q;
  end

endmodule

// File: tb/tb_pc_sequencer_irq.sv
// Bench for pc_sequencer_irq: directed scenarios followed by random cycles,
// all compared against a cycle-level reference model of the sequencing rules.
module tb_pc_sequencer_irq;

  localparam logic [31:0] RST_V = 32'h8000_0000;
  localparam logic [31:0] IRQ_V = 32'h8000_0004;
  localparam logic [31:0] EXC_V = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset, stall, exc_undef, irq_in;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jr_target;
  logic [25:0] jump_index;
  logic [31:0] pc, k0_wdata;
  logic        kernel, flush, k0_we, irq_pending;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_pend, m_prev, m_valid;

  pc_sequencer_irq dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .exc_undef     (exc_undef),
    .irq_in        (irq_in),
    .pc            (pc),
    .kernel        (kernel),
    .flush         (flush),
    .k0_we         (k0_we),
    .k0_wdata      (k0_wdata),
    .irq_pending   (irq_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model,
  // then check registered state just after the edge.
  task automatic step();
    logic        x_exc, x_irq, x_we, rise;
    logic [31:0] x_wd, t;
    #4;
    x_exc = exc_undef && !stall;
    x_irq = m_pend && !m_pc[31] && !stall && !exc_undef;
    x_we  = !reset && (x_exc || x_irq);
    x_wd  = x_exc ? m_pc + 32'd4 : m_pc;
    if (m_valid) begin
      chk("flush", {31'd0, flush}, {31'd0, x_we});
      chk("k0_we", {31'd0, k0_we}, {31'd0, x_we});
      if (x_we) chk("k0_wdata", k0_wdata, x_wd);
    end
    if (reset) begin
      m_pc = RST_V; m_pend = 1'b0; m_prev = 1'b0; m_valid = 1'b1;
    end else begin
      rise   = irq_in && !m_prev;
      m_prev = irq_in;
      if (rise) m_pend = 1'b1;
      else if (x_irq) m_pend = 1'b0;
      if (x_exc) m_pc = EXC_V;
      else if (x_irq) m_pc = IRQ_V;
      else if (!stall) begin
        case (pc_src)
          2'd0: m_pc = m_pc + 32'd4;
          2'd1: m_pc = branch_target & ~32'd3;
          2'd2: m_pc = {m_pc[31:28], 28'd0} + {4'd0, jump_index, 2'b00};
          default: begin
            t = jr_target & ~32'd3;
            if (!m_pc[31]) t = t & 32'h7FFF_FFFF;
            m_pc = t;
          end
        endcase
      end
    end
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("pc", pc, m_pc);
      chk("kernel", {31'd0, kernel}, {31'd0, m_pc[31]});
      chk("irq_pending", {31'd0, irq_pending}, {31'd0, m_pend});
    end
  endtask

  initial begin
    m_valid = 1'b0; m_pc = '0; m_pend = 1'b0; m_prev = 1'b0;
    reset = 1'b1; stall = 1'b0; exc_undef = 1'b0; irq_in = 1'b0;
    pc_src = 2'd1; branch_target = 32'h40; jr_target = '0; jump_index = '0;

    // Reset held two cycles while a branch is requested
    step(); step();
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_pend", {31'd0, irq_pending}, 32'd0);
    reset = 1'b0; pc_src = 2'd0;
    step(); chk("seq1", pc, 32'h8000_0004);
    step(); chk("seq2", pc, 32'h8000_0008);

    // Kernel to user handoff, then jump
    reset = 1'b1; step(); reset = 1'b0;
    pc_src = 2'd3; jr_target = 32'h0000_0044;
    step(); chk("handoff_pc", pc, 32'h44); chk("handoff_k", {31'd0, kernel}, 32'd0);
    pc_src = 2'd2; jump_index = 26'h1A;
    step(); chk("jump_pc", pc, 32'h68);

    // Interrupt from user mode at 0x70
    pc_src = 2'd1; branch_target = 32'h70;
    step(); chk("at70", pc, 32'h70);
    irq_in = 1'b1;
    step(); chk("irq_latch", {31'd0, irq_pending}, 32'd1); chk("irq_pc_hold", pc, 32'h70);
    #4;
    chk("irq_flush", {31'd0, flush}, 32'd1);
    chk("irq_k0we", {31'd0, k0_we}, 32'd1);
    chk("irq_k0wd", k0_wdata, 32'h70);
    @(posedge clk); #1;
    m_pc = IRQ_V; m_pend = 1'b0; m_prev = 1'b1;
    chk("irq_vec", pc, IRQ_V); chk("irq_clr", {31'd0, irq_pending}, 32'd0);
    pc_src = 2'd3; jr_target = 32'h70;
    step(); chk("ret70", pc, 32'h70);
    pc_src = 2'd0;
    step(); chk("noretake", pc, 32'h74);

    // Deferral while in kernel mode
    exc_undef = 1'b1; step(); exc_undef = 1'b0;
    chk("exc_vec", pc, EXC_V);
    pc_src = 2'd1; branch_target = 32'h8000_0190; irq_in = 1'b0;
    step(); chk("k190", pc, 32'h8000_0190);
    irq_in = 1'b1;
    step(); chk("defer_pend", {31'd0, irq_pending}, 32'd1);
    step(); chk("defer_hold", pc, 32'h8000_0190);
    pc_src = 2'd3; jr_target = 32'h70;
    step(); chk("defer_ret", pc, 32'h70);
    pc_src = 2'd0;
    step(); chk("defer_take", pc, IRQ_V);

    // Stall and exception priority over a pending interrupt
    irq_in = 1'b0; pc_src = 2'd3; jr_target = 32'h80;
    step(); chk("at80", pc, 32'h80);
    irq_in = 1'b1; stall = 1'b1;
    step(); chk("stall_hold", pc, 32'h80);
    step(); chk("stall_hold2", pc, 32'h80);
    stall = 1'b0; exc_undef = 1'b1;
    #4; chk("prio_k0wd", k0_wdata, 32'h84);
    step(); exc_undef = 1'b0;
    chk("prio_exc", pc, EXC_V); chk("prio_pend", {31'd0, irq_pending}, 32'd1);
    pc_src = 2'd3; jr_target = 32'h20;
    step(); step(); chk("after_take", pc, IRQ_V);
    step(); chk("at20", pc, 32'h20);

    // jr protection from user mode
    jr_target = 32'h8000_0010;
    step(); chk("prot_pc", pc, 32'h10); chk("prot_k", {31'd0, kernel}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(63) == 0);
      stall         = ($urandom_range(7) == 0);
      exc_undef     = ($urandom_range(15) == 0);
      if ($urandom_range(3) == 0) irq_in = ~irq_in;
      pc_src        = 2'($urandom_range(3));
      branch_target = $urandom;
      jr_target     = $urandom;
      jump_index    = 26'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer_irq.md
Name: pc_sequencer_irq

Overview:
- Owns the program counter for the single-cycle MIPS core and selects the next fetch address for the instruction memory.
- Next-address sources: sequential, branch, jump, jr, reset vector, interrupt vector, exception vector.
- Implements kernel mode as PC[31]: it latches timer interrupts, squashes the preempted instruction and supplies the return address for $k0.
- Sits between the decode/control unit and the instruction memory address port.

Parameters:
- RESET_VEC, 32'h8000_0000, PC value loaded on reset (kernel mode, word 0).
- IRQ_VEC, 32'h8000_0004, interrupt handler entry (word 1).
- EXC_VEC, 32'h8000_0008, undefined-instruction handler entry (word 2).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC, suppress interrupt/exception take
- pc_src  in  2  0=PC+4, 1=branch, 2=jump, 3=jr
- branch_target  in  32  precomputed PC+4+offset
- jump_index  in  26  instruction[25:0]
- jr_target  in  32  rs register value
- exc_undef  in  1  decoder flags current instruction undefined
- irq_in  in  1  timer interrupt level (TCON status)
- pc  out  32  current fetch address
- kernel  out  1  equals pc[31]
- flush  out  1  squash reg/mem writes of current instruction (combinational)
- k0_we  out  1  write $k0 this cycle (combinational)
- k0_wdata  out  32  return address for $k0
- irq_pending  out  1  latched interrupt awaiting service

Behaviour:
- Reset (synchronous, active-high): pc=RESET_VEC, irq_pending=0, irq_in_d=0. At the next edge after reset, flush/k0_we are 0. Reset mid-operation overrides everything, including a pending take.
- Edge detector: irq_in_d <= irq_in every cycle. The rise condition is irq_in & ~irq_in_d.
- Pending latch:
  - Set on rise.
  - Cleared on the cycle an interrupt is taken.
  - If set and clear happen in the same cycle, set wins.
  - A rise while in kernel mode stays pending until the PC returns to user mode.
- take_exc = exc_undef & ~stall. Exceptions are taken in either mode.
- take_irq = irq_pending & ~kernel & ~stall & ~exc_undef.
- Priority, highest first:
  - reset
  - take_exc: next pc = EXC_VEC; flush=1; k0_we=1; k0_wdata=pc+4 (faulting instruction skipped).
  - take_irq: next pc = IRQ_VEC; flush=1; k0_we=1; k0_wdata=pc (preempted instruction re-executed after jr $k0).
  - stall: pc holds.
  - Otherwise, by pc_src:
    - 0: next pc = pc+4
    - 1: next pc = branch_target
    - 2: next pc = {pc[31:28], jump_index, 2'b00}, which preserves the kernel bit
    - 3: next pc = jr_target
- jr protection: in user mode (pc[31]=0), jr_target[31] is forced to 0, so user code cannot enter kernel mode except through a vector. In kernel mode, jr_target is used unmodified; jr $k0 with bit31=0 returns to user mode.
- Arithmetic: pc+4 wraps modulo 2^32. pc[1:0] is always 0; branch_target[1:0] and jr_target[1:0] are masked to 0.
- Latency: all outputs except pc are combinational from the current pc and inputs. pc updates on the next rising edge. Interrupt latency is 2 edges from irq_in rise (latch edge, then vector edge) when in user mode and not stalled.
- Exceptions inside the handler are permitted. $k0 is overwritten, and software must save it.

Test Plan:
- Reset: assert reset 2 cycles with pc_src=1, branch_target=0x40 -> pc=0x8000_0000, irq_pending=0; after release with pc_src=0, pc steps 0x8000_0004, 0x8000_0008.
- Kernel-to-user handoff: at pc=0x8000_0000 drive pc_src=3, jr_target=0x0000_0044 -> pc=0x0000_0044, kernel=0. Then pc_src=2, jump_index=0x1A -> pc=0x0000_0068.
- Interrupt: user pc=0x0000_0070, raise irq_in -> next edge irq_pending=1; following cycle flush=1, k0_we=1, k0_wdata=0x0000_0070; pc=0x8000_0004; irq_pending=0. Holding irq_in high causes no retake.
- Masking/deferral: irq rise while pc=0x8000_0190 -> irq_pending=1 held, no take. Handler jr to jr_target=0x0000_0070 -> pc=0x0000_0070, then next cycle take to 0x8000_0004.
- Priority/stall: user mode, irq_pending=1 with exc_undef=1 at pc=0x0000_0080 -> pc=0x8000_0008, k0_wdata=0x0000_0084, irq_pending stays 1. With stall=1 and irq_pending=1 -> pc holds, flush=0.
- Protection: user pc=0x0000_0020, pc_src=3, jr_target=0x8000_0010 -> pc=0x0000_0010, kernel=0.
